// File: rtl/medidor_eco_cm.sv
`default_nettype none
// ============================================================================
//  Module   : medidor_eco_cm
//  Purpose  : Measures the high time of the sonar echo pulse and converts it
//             to centimetres as D packed BCD digits. The result goes to an
//             output register, so the previous result stays visible while a
//             new pulse is counted. A long pulse stops at TIMEOUT_CM and the
//             result saturates. pronto pulses once per result, and valido
//             stays high while digitos holds a complete measurement.
//  Options  : MEDIDOR_ARREDONDA_EN - round the result to the nearest cm
//             (half cm rounds up) instead of truncating it.
//  Revision : 1.0 - initial release
// ============================================================================
module medidor_eco_cm #(
  parameter int R          = 2941,
  parameter int N          = 12,
  parameter int D          = 3,
  parameter int TIMEOUT_CM = 400
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           pulso,
  output logic [4*D-1:0] digitos,
  output logic           pronto,
  output logic           valido,
  output logic           timeout,
  output logic [2:0]     db_estado
);

  typedef enum logic [2:0] {
    ST_OCIOSO       = 3'd0,
    ST_CONTANDO     = 3'd1,
    ST_FINAL        = 3'd2,
    ST_TIMEOUT      = 3'd3,
    ST_ESPERA_BAIXO = 3'd4
  } state_t;

  // Converts an integer to packed BCD. Used only on constants at elaboration.
  function automatic logic [4*D-1:0] to_bcd(input int value);
    logic [4*D-1:0] r;
    int             v;
    r = '0;
    v = value;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  localparam logic [4*D-1:0] c_timeout_bcd = to_bcd(TIMEOUT_CM);
  localparam logic [N-1:0]   c_tick_last   = N'(R - 1);

  state_t         state_q, state_d;
  logic [N-1:0]   tick_q, tick_d;
  logic [4*D-1:0] bcd_q, bcd_d;
  logic [4*D-1:0] digitos_q, digitos_d;
  logic           pronto_q, pronto_d;
  logic           valido_q, valido_d;
  logic           timeout_q, timeout_d;

  logic [4*D-1:0] w_bcd_inc;
  logic [D-1:0]   w_carry;
  logic [4*D-1:0] w_result;

  // Decimal increment of the working counter: a digit rolls 9->0 and
  // passes a carry to the next digit only when every lower digit rolled.
  assign w_carry[0] = 1'b1;
  for (genvar i = 0; i < D; i++) begin : g_digit
    logic [3:0] w_dig;
    assign w_dig = bcd_q[4*i +: 4];
    assign w_bcd_inc[4*i +: 4] = !w_carry[i]   ? w_dig :
                                 (w_dig == 4'd9) ? 4'd0 : w_dig + 4'd1;
    if (i < D - 1) begin : g_carry
      assign w_carry[i+1] = w_carry[i] & (w_dig == 4'd9);
    end
  end

`ifdef MEDIDOR_ARREDONDA_EN
  // Round up when the leftover ticks are at least half a cm. The count can
  // never be at TIMEOUT_CM here, but the clamp keeps the result in range.
  localparam logic [N+1:0] c_r_ext = (N+2)'(R);
  logic w_round_up;
  assign w_round_up = ({1'b0, tick_q, 1'b0} >= c_r_ext) && (bcd_q != c_timeout_bcd);
  assign w_result   = w_round_up ? w_bcd_inc : bcd_q;
`else
  assign w_result = bcd_q;
`endif

  // Next-state and register-update logic for the measurement sequence.
  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bcd_d     = bcd_q;
    digitos_d = digitos_q;
    pronto_d  = 1'b0;
    valido_d  = valido_q;
    timeout_d = timeout_q;
    case (state_q)
      ST_OCIOSO: begin
        bcd_d = '0;
        if (pulso) begin
          tick_d   = N'(1);
          valido_d = 1'b0;
          state_d  = ST_CONTANDO;
        end else begin
          tick_d = '0;
        end
      end
      ST_CONTANDO: begin
        // A falling pulse has priority over reaching the timeout count.
        if (!pulso) begin
          state_d = ST_FINAL;
        end else if (tick_q == c_tick_last) begin
          tick_d = '0;
          bcd_d  = w_bcd_inc;
          if (w_bcd_inc == c_timeout_bcd) begin
            state_d = ST_TIMEOUT;
          end
        end else begin
          tick_d = tick_q + N'(1);
        end
      end
      ST_FINAL: begin
        digitos_d = w_result;
        timeout_d = 1'b0;
        pronto_d  = 1'b1;
        valido_d  = 1'b1;
        state_d   = ST_OCIOSO;
      end
      ST_TIMEOUT: begin
        digitos_d = c_timeout_bcd;
        timeout_d = 1'b1;
        pronto_d  = 1'b1;
        valido_d  = 1'b1;
        state_d   = ST_ESPERA_BAIXO;
      end
      ST_ESPERA_BAIXO: begin
        // Let the rest of an over-long pulse pass without measuring it.
        if (!pulso) begin
          state_d = ST_OCIOSO;
        end
      end
      default: begin
        state_d = ST_OCIOSO;
      end
    endcase
  end

  // State and data registers, cleared asynchronously by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_OCIOSO;
      tick_q    <= '0;
      bcd_q     <= '0;
      digitos_q <= '0;
      pronto_q  <= 1'b0;
      valido_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bcd_q     <= bcd_d;
      digitos_q <= digitos_d;
      pronto_q  <= pronto_d;
      valido_q  <= valido_d;
      timeout_q <= timeout_d;
    end
  end

  assign digitos   = digitos_q;
  assign pronto    = pronto_q;
  assign valido    = valido_q;
  assign timeout   = timeout_q;
  assign db_estado = state_q;

endmodule
`default_nettype wire

// File: tb/tb_medidor_eco_cm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_medidor_eco_cm
//  Purpose  : Scoreboard bench for medidor_eco_cm with R=10, D=3,
//             TIMEOUT_CM=25. Expected results come from pulse lengths by
//             plain arithmetic. Define MEDIDOR_ARREDONDA_EN for both files
//             to check the rounding build.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_medidor_eco_cm;

  localparam int R  = 10;
  localparam int N  = 4;
  localparam int D  = 3;
  localparam int TO = 25;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        pulso = 1'b0;
  logic [11:0] digitos;
  logic        pronto;
  logic        valido;
  logic        timeout;
  logic [2:0]  db_estado;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit prev_final = 1'b0;

  typedef struct {
    logic [11:0] dig;
    logic        to;
    int          cyc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  medidor_eco_cm #(.R(R), .N(N), .D(D), .TIMEOUT_CM(TO)) dut (
    .clock     (clock),
    .reset     (reset),
    .pulso     (pulso),
    .digitos   (digitos),
    .pronto    (pronto),
    .valido    (valido),
    .timeout   (timeout),
    .db_estado (db_estado)
  );

  always #5 clock = ~clock;

  // Edge index: after the k-th rising edge cyc equals k.
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [11:0] bcd(input int v);
    return {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Reference: L counted high cycles -> cm, saturated at the timeout.
  task automatic model(input int len, output logic [11:0] dig, output logic to);
    int cm;
    if (len >= TO * R) begin
      dig = bcd(TO);
      to  = 1'b1;
    end else begin
      cm = len / R;
`ifdef MEDIDOR_ARREDONDA_EN
      if (2 * (len % R) >= R) cm = cm + 1;
      if (cm > TO) cm = TO;
`endif
      dig = bcd(cm);
      to  = 1'b0;
    end
  endtask

  // pulso is already high; keep it high for h edges, of which the first s
  // are not counted by the meter. Pushes the expected result and time.
  task automatic run_high(input int h, input int s);
    exp_t e;
    int   c0;
    c0 = cyc;
    model(h - s, e.dig, e.to);
    e.cyc = e.to ? (c0 + s + R * TO + 1) : (c0 + h + 2);
    q.push_back(e);
    repeat (h) @(posedge clock);
    #1;
    if (e.to) begin
      if (h >= s + R * TO + 1) chk("db_estado_espera", 32'(db_estado), 32'd4);
    end else begin
      chk("valido_low_counting", 32'(valido), 32'd0);
    end
    pulso = 1'b0;
    prev_final = !e.to;
  endtask

  // g low edges, then an h-edge pulse. With a single low edge right after
  // a normal result, the first high edge falls in the result cycle and is lost.
  task automatic do_pulse(input int h, input int g);
    int s;
    s = (prev_final && g == 1) ? 1 : 0;
    repeat (g) @(posedge clock);
    #1;
    pulso = 1'b1;
    run_high(h, s);
  endtask

  // Monitor: every pronto pulse is matched against the scoreboard.
  always @(negedge clock) begin
    if (pronto === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pronto: got pronto=1 at cycle %0d, required no pulse", cyc);
      end else begin
        mon_e = q.pop_front();
        chk("digitos", 32'(digitos), 32'(mon_e.dig));
        chk("timeout", 32'(timeout), 32'(mon_e.to));
        chk("valido_at_pronto", 32'(valido), 32'd1);
        chk("pronto_cycle", 32'(cyc), 32'(mon_e.cyc));
      end
    end
  end

  initial begin
    int k;
    // Reset only.
    repeat (3) @(posedge clock);
    #1;
    chk("rst_digitos", 32'(digitos), 32'd0);
    chk("rst_pronto", 32'(pronto), 32'd0);
    chk("rst_valido", 32'(valido), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_db_estado", 32'(db_estado), 32'd0);
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("idle_digitos", 32'(digitos), 32'd0);
    chk("idle_db_estado", 32'(db_estado), 32'd0);

    // Directed cases.
    do_pulse(47, 3);
    do_pulse(5, 4);
    do_pulse(44, 4);
    do_pulse(400, 4);
    do_pulse(47, 4);

    // Reset 20 cycles into a pulse that stays high through the release.
    repeat (4) @(posedge clock);
    #1;
    pulso = 1'b1;
    repeat (20) @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    chk("midrst_digitos", 32'(digitos), 32'd0);
    chk("midrst_pronto", 32'(pronto), 32'd0);
    chk("midrst_valido", 32'(valido), 32'd0);
    chk("midrst_timeout", 32'(timeout), 32'd0);
    chk("midrst_db_estado", 32'(db_estado), 32'd0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    prev_final = 1'b0;
    run_high(123, 0);

    // Two pulses with a single idle cycle between them.
    do_pulse(31, 4);
    do_pulse(62, 1);

    // Randomised pulses, including ones that hit the timeout.
    for (int i = 0; i < 20; i++) begin
      do_pulse(int'($urandom_range(300, 2)), int'($urandom_range(6, 1)));
    end

    // Drain with a bound, then idle to catch stray pronto pulses.
    k = 0;
    while (q.size() > 0 && k < 1000) begin
      @(posedge clock);
      k++;
    end
    repeat (10) @(posedge clock);
    #1;
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
